// File: rtl/oam_dma_if.sv
// CPU-side and system-bus-side signal bundle for the OAM DMA controller.
// The master modport is the controller; the slave modport is the CPU/bus environment.
interface oam_dma_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic          cpu_rnw;
  logic [DW-1:0] bus_din;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_dout;
  logic          bus_rnw;
  logic          cpu_rdy;
  logic          dma_active;

  modport master (
    input  cpu_addr, cpu_dout, cpu_rnw, bus_din,
    output bus_addr, bus_dout, bus_rnw, cpu_rdy, dma_active
  );

  modport slave (
    output cpu_addr, cpu_dout, cpu_rnw, bus_din,
    input  bus_addr, bus_dout, bus_rnw, cpu_rdy, dma_active
  );
endinterface

// File: rtl/oam_dma_controller.sv
// Sprite-OAM DMA: a CPU write to 0x4014 halts the CPU and copies page*256..+255 to 0x2004.
// Bus muxing is combinational so the CPU owns the bus transparently while idle.
module oam_dma_controller (
  input  logic        clk,
  input  logic        rst,
  oam_dma_if.master   io
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] TRIG_ADDR     = 16'h4014;
  localparam logic [AW-1:0] OAM_DATA_ADDR = 16'h2004;
  localparam logic [DW-1:0] LAST_INDEX    = 8'hFF;

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] page, page_d;
  logic [DW-1:0] index, index_d;
  logic [DW-1:0] latch, latch_d;
  logic          parity;

  // State and datapath registers; parity free-runs so READ can be phase-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      page   <= '0;
      index  <= '0;
      latch  <= '0;
      parity <= 1'b0;
    end else begin
      state  <= state_d;
      page   <= page_d;
      index  <= index_d;
      latch  <= latch_d;
      parity <= ~parity;
    end
  end

  // Next-state, datapath updates and bus mux.
  always_comb begin
    state_d     = state;
    page_d      = page;
    index_d     = index;
    latch_d     = latch;
    io.bus_addr = io.cpu_addr;
    io.bus_dout = io.cpu_dout;
    io.bus_rnw  = io.cpu_rnw;

    unique case (state)
      IDLE: begin
        if (!io.cpu_rnw && (io.cpu_addr == TRIG_ADDR)) begin
          page_d  = io.cpu_dout;
          index_d = '0;
          state_d = HALT;
        end
      end
      HALT: begin
        io.bus_rnw = 1'b1;
        state_d    = parity ? READ : ALIGN;
      end
      ALIGN: begin
        io.bus_rnw = 1'b1;
        state_d    = READ;
      end
      READ: begin
        io.bus_addr = {page, index};
        io.bus_rnw  = 1'b1;
        latch_d     = io.bus_din;
        state_d     = WRITE;
      end
      WRITE: begin
        io.bus_addr = OAM_DATA_ADDR;
        io.bus_dout = latch;
        io.bus_rnw  = 1'b0;
        if (index == LAST_INDEX) begin
          state_d = IDLE;
        end else begin
          index_d = DW'(index + 8'd1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.cpu_rdy    = (state == IDLE);
  assign io.dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: IDLE pass-through vectors plus scoreboarded DMA runs.
module tb_oam_dma_controller;
  logic clk;
  logic rst;
  logic [7:0] key;
  logic tb_par;
  int checks;
  int errors;

  oam_dma_if ifc ();

  oam_dma_controller dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  // Memory model: every read returns low address byte XOR key.
  assign ifc.bus_din = ifc.bus_addr[7:0] ^ key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference parity phase, counted from reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_par <= 1'b0;
    else      tb_par <= ~tb_par;
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rnw;
    logic [15:0] e_addr;
    logic [7:0]  e_dout;
    logic        e_rnw;
    logic        e_rdy;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rnw;
    logic        chk_dout;
    logic        is_read;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cpu_drive(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    ifc.cpu_addr = a;
    ifc.cpu_dout = d;
    ifc.cpu_rnw  = rnw;
  endtask

  task automatic run_dma(input logic [7:0] page, input logic halt_par, input logic [7:0] key_in,
                         input bit inject, input bit do_rst);
    exp_t e;
    int   stall;
    int   guard;
    bit   done;
    key = key_in;
    sb.delete();
    guard = 0;
    @(negedge clk);
    while ((tb_par != ~halt_par) && (guard < 4)) begin
      @(negedge clk);
      guard++;
    end
    cpu_drive(16'h4014, page, 1'b0);
    #1;
    chk("trig_addr", 32'(ifc.bus_addr), 32'h4014);
    chk("trig_rnw", 32'(ifc.bus_rnw), 32'h0);
    chk("trig_dout", 32'(ifc.bus_dout), 32'(page));
    chk("trig_rdy", 32'(ifc.cpu_rdy), 32'h1);

    e = '{addr: 16'h1234, dout: 8'h99, rnw: 1'b1, chk_dout: 1'b1, is_read: 1'b0, idx: 8'h00};
    sb.push_back(e);
    if (!halt_par) sb.push_back(e);
    for (int i = 0; i < 256; i++) begin
      e = '{addr: {page, 8'(i)}, dout: 8'h00, rnw: 1'b1, chk_dout: 1'b0, is_read: 1'b1, idx: 8'(i)};
      sb.push_back(e);
      e = '{addr: 16'h2004, dout: 8'(i) ^ key_in, rnw: 1'b0, chk_dout: 1'b1, is_read: 1'b0, idx: 8'(i)};
      sb.push_back(e);
    end

    stall = 0;
    done  = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      if (c == 0) cpu_drive(16'h1234, 8'h99, 1'b1);
      else if (inject && stall == 20) cpu_drive(16'h4014, 8'h07, 1'b0);
      else if (inject && stall == 21) cpu_drive(16'h1234, 8'h99, 1'b1);
      #1;
      if (ifc.cpu_rdy) begin
        done = 1;
      end else begin
        stall++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("dma_addr", 32'(ifc.bus_addr), 32'(e.addr));
          chk("dma_rnw", 32'(ifc.bus_rnw), 32'(e.rnw));
          if (e.chk_dout) chk("dma_dout", 32'(ifc.bus_dout), 32'(e.dout));
          chk("dma_active", 32'(ifc.dma_active), 32'h1);
          if (e.is_read) chk("read_parity", 32'(tb_par), 32'h0);
          if (do_rst && e.is_read && e.idx == 8'h40) begin
            rst = 1'b0;
            #1;
            chk("rst_rdy", 32'(ifc.cpu_rdy), 32'h1);
            chk("rst_active", 32'(ifc.dma_active), 32'h0);
            chk("rst_addr", 32'(ifc.bus_addr), 32'h1234);
            chk("rst_rnw", 32'(ifc.bus_rnw), 32'h1);
            @(negedge clk);
            chk("rst_hold_rdy", 32'(ifc.cpu_rdy), 32'h1);
            rst = 1'b1;
            for (int k = 0; k < 6; k++) begin
              @(negedge clk);
              #1;
              chk("post_rst_rdy", 32'(ifc.cpu_rdy), 32'h1);
              chk("post_rst_active", 32'(ifc.dma_active), 32'h0);
              chk("post_rst_no_oam_wr", 32'((ifc.bus_addr == 16'h2004) && !ifc.bus_rnw), 32'h0);
            end
            sb.delete();
            done = 1;
          end
        end
      end
    end
    if (!done) chk("dma_timeout", 32'h1, 32'h0);
    if (!do_rst) begin
      chk("stall_cycles", 32'(stall), halt_par ? 32'd513 : 32'd514);
      chk("sb_empty", 32'(sb.size()), 32'h0);
      chk("end_active", 32'(ifc.dma_active), 32'h0);
      chk("end_pass_addr", 32'(ifc.bus_addr), 32'h1234);
      chk("end_pass_rnw", 32'(ifc.bus_rnw), 32'h1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    checks = 0;
    errors = 0;
    key    = 8'h5A;
    rst    = 1'b0;
    cpu_drive(16'h0000, 8'h00, 1'b1);

    vecs[0] = '{16'h0300, 8'hAB, 1'b0, 16'h0300, 8'hAB, 1'b0, 1'b1};
    vecs[1] = '{16'hC000, 8'h00, 1'b1, 16'hC000, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{16'h4015, 8'h11, 1'b0, 16'h4015, 8'h11, 1'b0, 1'b1};
    vecs[3] = '{16'h4014, 8'h22, 1'b1, 16'h4014, 8'h22, 1'b1, 1'b1};
    vecs[4] = '{16'h2004, 8'h33, 1'b0, 16'h2004, 8'h33, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_rdy", 32'(ifc.cpu_rdy), 32'h1);
    chk("reset_active", 32'(ifc.dma_active), 32'h0);
    rst = 1'b1;

    // IDLE pass-through, including a read of 0x4014 which must not trigger.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cpu_drive(vecs[i].addr, vecs[i].dout, vecs[i].rnw);
      #1;
      chk("idle_addr", 32'(ifc.bus_addr), 32'(vecs[i].e_addr));
      chk("idle_dout", 32'(ifc.bus_dout), 32'(vecs[i].e_dout));
      chk("idle_rnw", 32'(ifc.bus_rnw), 32'(vecs[i].e_rnw));
      chk("idle_rdy", 32'(ifc.cpu_rdy), 32'(vecs[i].e_rdy));
    end
    @(negedge clk);
    cpu_drive(16'h1234, 8'h99, 1'b1);
    #1;
    chk("idle_rdy_after", 32'(ifc.cpu_rdy), 32'h1);

    run_dma(8'h02, 1'b1, 8'h5A, 1'b0, 1'b0);
    run_dma(8'h02, 1'b0, 8'h5A, 1'b0, 1'b0);
    run_dma(8'h02, 1'b1, 8'h5A, 1'b1, 1'b0);
    run_dma(8'h02, 1'b0, 8'h5A, 1'b0, 1'b1);
    run_dma(8'hFF, 1'b1, 8'h3C, 1'b0, 1'b0);
    run_dma(8'h00, 1'b0, 8'hC3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/oam_dma_controller.md
OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state changes on posedge clk.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port cpu_addr, input, 16: CPU address bus (Addr_bus).
REQ-004 SHALL have port cpu_dout, input, 8: CPU write data (Data_bus_out).
REQ-005 SHALL have port cpu_rnw, input, 1: CPU read/not-write.
REQ-006 SHALL have port bus_din, input, 8: read data returned from the system bus.
REQ-007 SHALL have port bus_addr, output, 16: muxed system-bus address.
REQ-008 SHALL have port bus_dout, output, 8: muxed system-bus write data.
REQ-009 SHALL have port bus_rnw, output, 1: muxed system-bus read/not-write.
REQ-010 SHALL have port cpu_rdy, output, 1: CPU ready; 0 = CPU halted.
REQ-011 SHALL have port dma_active, output, 1: 1 whenever state != IDLE.

Function
REQ-012 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE.
REQ-013 SHALL hold an 8-bit page register, an 8-bit index, an 8-bit data latch and a 1-bit parity flag.
REQ-014 Parity SHALL toggle on every clk edge, independent of state.
REQ-015 Trigger: in IDLE, a cycle with cpu_rnw=0 and cpu_addr=16'h4014 SHALL latch cpu_dout into page, clear index, and move to HALT on the next edge.
REQ-016 HALT SHALL last exactly 1 cycle, then go to READ if parity=1 during HALT, else to ALIGN.
REQ-017 ALIGN SHALL last exactly 1 cycle, then go to READ, so that every READ cycle has parity=0.
REQ-018 READ cycle: bus_addr={page,index}, bus_rnw=1; bus_din SHALL be captured into the data latch at the end of the cycle; next state is WRITE.
REQ-019 WRITE cycle: bus_addr=16'h2004, bus_dout=latch, bus_rnw=0.
REQ-020 After WRITE: if index=8'hFF, go to IDLE; else increment index and go to READ.
REQ-021 Total stall SHALL be 513 cycles when the HALT parity is 1 and 514 cycles when it is 0 (1 HALT + 0/1 ALIGN + 512 READ/WRITE).
REQ-022 cpu_rdy SHALL be 0 in HALT, ALIGN, READ and WRITE, and 1 in IDLE.
REQ-023 cpu_rdy SHALL return to 1 in the cycle after the final WRITE.
REQ-024 In IDLE, bus_addr/bus_dout/bus_rnw SHALL pass through cpu_addr/cpu_dout/cpu_rnw combinationally.
REQ-025 In HALT and ALIGN: bus_addr=cpu_addr, bus_dout=cpu_dout, bus_rnw forced to 1 (dummy read, no write).
REQ-026 A write to 16'h4014 while not IDLE SHALL be ignored; page SHALL be unchanged.
REQ-027 The trigger write itself SHALL also pass to the bus (bus_rnw=0, bus_addr=16'h4014) in the trigger cycle.
REQ-028 Index SHALL wrap only via the terminal check in REQ-020; the page SHALL never increment.
REQ-029 Any page value 8'h00..8'hFF SHALL be legal.

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, cpu_rdy=1, dma_active=0, page=0, index=0, latch=0, parity=0.
REQ-031 Assertion of rst mid-transfer SHALL abort immediately with no further bus writes; the first edge after release SHALL be in IDLE.

Verification
REQ-032 Write 8'h02 to 16'h4014 with HALT parity=1 -> cpu_rdy low 513 cycles; reads 16'h0200..16'h02FF each followed by a write of that byte to 16'h2004.
REQ-033 Same write with HALT parity=0 -> one ALIGN cycle; cpu_rdy low 514 cycles; every READ cycle has parity=0.
REQ-034 bus_din pattern = low byte of address XOR 8'h5A -> the 256 WRITE cycles present the matching values in order.
REQ-035 Second write to 16'h4014 (value 8'h07) during READ/WRITE -> ignored; transfer still completes from the original page.
REQ-036 rst pulsed low at index 8'h40 -> cpu_rdy=1, state IDLE, no 16'h2004 write after the pulse; a new trigger restarts at index 0.
REQ-037 IDLE traffic: CPU write 8'hAB to 16'h0300 and read from 16'hC000 -> bus signals mirror the CPU exactly; cpu_rdy stays 1.
